// File: rtl/gfb_hs_pkg.sv
// Shared definitions for the GFB CMD/RESP handshake blocks: state encoding,
// command opcodes and default data width.
package gfb_hs_pkg;

  localparam int GFB_DATA_W = 10;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_ACK_LOW = 2'd2
  } hs_state_e;

  typedef enum logic [2:0] {
    CMD_IDLE       = 3'd0,
    CMD_READ       = 3'd1,
    CMD_WRITE      = 3'd2,
    CMD_ROW_WRITE  = 3'd3,
    CMD_ERASE      = 3'd4,
    CMD_MASS_ERASE = 3'd5
  } gfb_cmd_e;

  function automatic logic hs_busy(input hs_state_e s);
    return s != HS_IDLE;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit flop-chain synchronizer with synchronous reset; STAGES is
// expected to be 2..4. Shared by the sclk transmitter and the pclk receiver.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rsp_handshake_tx_sclk.sv
// SCLK-side response transmitter: holds RDATA/RESP for a 4-phase req/ack
// handshake with a one-entry pending buffer. Optional ack timeout: RSP_TIMEOUT_EN.
//
// state      | meaning
// HS_IDLE    | no transfer held, req low, waiting for rsp_valid
// HS_REQ     | req high, data held, waiting for synchronized ack high
// HS_ACK_LOW | req low, waiting for synchronized ack to return low
module rsp_handshake_tx_sclk
  import gfb_hs_pkg::*;
#(
  parameter int DATA_W      = GFB_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              SCLK,
  input  logic              RESET_sclk,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_err,
  output logic              rsp_ready,
  output logic [DATA_W-1:0] RDATA_REG_sclk,
  output logic              RESP_REG_sclk,
  output logic              rsp_req_sclk,
  input  logic              rsp_ack_pclk,
  output logic              ovf_sclk,
  output logic              tmo_sclk
);

  hs_state_e         state_q;
  logic [DATA_W-1:0] rdata_q;
  logic              resp_q;
  logic              req_q;
  logic              pend_full_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              pend_err_q;
  logic              ovf_q;
  logic              ack_s;
  logic              pend_store_d;
  logic              pend_drop_d;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (SCLK),
    .rst_i (RESET_sclk),
    .d_i   (rsp_ack_pclk),
    .q_o   (ack_s)
  );

  // Strobes arriving while a transfer is held go to pending, or are dropped when it is full.
  assign pend_store_d = rsp_valid & hs_busy(state_q) & ~pend_full_q;
  assign pend_drop_d  = rsp_valid & hs_busy(state_q) &  pend_full_q;

`ifdef RSP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;
  logic             tmo_hit;
  logic             state_chg_d;

  assign tmo_hit = hs_busy(state_q) && (cnt_q == '0);

  always_comb begin
    state_chg_d = 1'b0;
    unique case (state_q)
      HS_IDLE:    state_chg_d = rsp_valid;
      HS_REQ:     state_chg_d = ack_s;
      HS_ACK_LOW: state_chg_d = ~ack_s;
      default:    state_chg_d = 1'b1;
    endcase
  end

  // Down-counter reloads on every state change; terminal count is zero.
  always_ff @(posedge SCLK) begin
    if (RESET_sclk || !hs_busy(state_q) || state_chg_d || tmo_hit) begin
      cnt_q <= CNT_LOAD;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tmo_sclk = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign tmo_sclk = 1'b0;
`endif

  always_ff @(posedge SCLK) begin
    if (RESET_sclk) begin
      state_q     <= HS_IDLE;
      rdata_q     <= '0;
      resp_q      <= 1'b0;
      req_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef RSP_TIMEOUT_EN
      tmo_q       <= 1'b0;
`endif
    end else begin
`ifdef RSP_TIMEOUT_EN
      if (tmo_hit) begin
        tmo_q       <= 1'b1;
        req_q       <= 1'b0;
        pend_full_q <= 1'b0;
        state_q     <= HS_IDLE;
      end else
`endif
      begin
        if (pend_store_d) begin
          pend_full_q <= 1'b1;
          pend_data_q <= rsp_data;
          pend_err_q  <= rsp_err;
        end
        if (pend_drop_d) begin
          ovf_q <= 1'b1;
        end

        unique case (state_q)
          HS_IDLE: begin
            if (rsp_valid) begin
              rdata_q <= rsp_data;
              resp_q  <= rsp_err;
              req_q   <= 1'b1;
              state_q <= HS_REQ;
            end
          end
          HS_REQ: begin
            if (ack_s) begin
              req_q   <= 1'b0;
              state_q <= HS_ACK_LOW;
            end
          end
          HS_ACK_LOW: begin
            if (!ack_s) begin
              if (pend_full_q || rsp_valid) begin
                // A strobe landing on this edge passes through pending straight into the regs.
                pend_full_q <= 1'b0;
                req_q       <= 1'b1;
                state_q     <= HS_REQ;
                if (pend_full_q) begin
                  rdata_q <= pend_data_q;
                  resp_q  <= pend_err_q;
                end else begin
                  rdata_q <= rsp_data;
                  resp_q  <= rsp_err;
                end
              end else begin
                state_q <= HS_IDLE;
              end
            end
          end
          default: begin
            req_q   <= 1'b0;
            state_q <= HS_IDLE;
          end
        endcase
      end
    end
  end

  assign rsp_ready      = ~hs_busy(state_q) | ~pend_full_q;
  assign RDATA_REG_sclk = rdata_q;
  assign RESP_REG_sclk  = resp_q;
  assign rsp_req_sclk   = req_q;
  assign ovf_sclk       = ovf_q;

endmodule
